// File: rtl/sram_port_arbiter.sv
// ---------------------------------------------------------------------------
// sram_port_arbiter
//
// Shares the single synchronous SRAM port between the instruction-fetch
// requester (I, read-only) and the data load/store requester (D). The SRAM
// returns read data one cycle after it is enabled, so every read grant is
// followed by exactly one response cycle routed back to whoever was granted.
//
// D normally wins when both ask. A starvation counter tracks how many
// consecutive cycles I has been denied by D; once it reaches STARVE_MAX, I is
// granted instead.
//
// Parameters
//   STARVE_MAX  consecutive D-over-I wins allowed before I is forced (>= 1)
//
// Ports
//   clk, rst                        clock, synchronous active-high reset
//   i_req, i_addr                   instruction read request and address
//   i_gnt, i_rvalid, i_rdata        instruction grant and read response
//   d_req, d_wen, d_addr, d_wdata   data request (d_wen == 0 means read)
//   d_gnt, d_rvalid, d_rdata        data grant and read response
//   sram_en, sram_wen, sram_addr,
//   sram_wdata                      SRAM command port
//   sram_rdata                      SRAM read data (one cycle after a read)
// ---------------------------------------------------------------------------
module sram_port_arbiter #(
   parameter int STARVE_MAX = 4
) (
   input  logic        clk,
   input  logic        rst,

   input  logic        i_req,
   input  logic [31:0] i_addr,
   output logic        i_gnt,
   output logic        i_rvalid,
   output logic [31:0] i_rdata,

   input  logic        d_req,
   input  logic [3:0]  d_wen,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   output logic        d_gnt,
   output logic        d_rvalid,
   output logic [31:0] d_rdata,

   output logic        sram_en,
   output logic [3:0]  sram_wen,
   output logic [31:0] sram_addr,
   output logic [31:0] sram_wdata,
   input  logic [31:0] sram_rdata
);

   localparam int CNT_W = $clog2(STARVE_MAX + 1);

   typedef enum logic [1:0] {
      RESP_NONE,
      RESP_INST,
      RESP_DATA
   } respOwner_t;

   logic [CNT_W-1:0] r_starveCnt;
   respOwner_t       r_respOwner;
   respOwner_t       w_respOwnerNext;
   logic             w_iGnt;
   logic             w_dGnt;
   logic             w_starveHit;

   assign w_starveHit = (r_starveCnt == CNT_W'(STARVE_MAX));

   // Arbitration: D has fixed priority unless I has been starved for
   // STARVE_MAX cycles in a row. Nothing is granted while reset is held.
   always_comb begin
      w_iGnt = 1'b0;
      w_dGnt = 1'b0;
      if (!rst) begin
         if (i_req && d_req) begin
            w_iGnt = w_starveHit;
            w_dGnt = !w_starveHit;
         end else begin
            w_iGnt = i_req;
            w_dGnt = d_req;
         end
      end
   end

   // Port mux: the granted requester drives the SRAM command; with no grant
   // every command field is held at zero so the bus is quiet.
   always_comb begin
      i_gnt      = w_iGnt;
      d_gnt      = w_dGnt;
      sram_en    = w_iGnt | w_dGnt;
      sram_wen   = 4'b0000;
      sram_addr  = 32'h0000_0000;
      sram_wdata = 32'h0000_0000;
      if (w_iGnt) begin
         sram_addr = i_addr;
      end else if (w_dGnt) begin
         sram_addr  = d_addr;
         sram_wen   = d_wen;
         sram_wdata = d_wdata;
      end
   end

   // Starvation counter: counts consecutive cycles in which a waiting I
   // request lost to D, saturating at STARVE_MAX. Any I grant, or I going
   // idle, restarts the count.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_starveCnt <= '0;
      end else if (w_iGnt || !i_req) begin
         r_starveCnt <= '0;
      end else if (w_dGnt && !w_starveHit) begin
         r_starveCnt <= r_starveCnt + CNT_W'(1);
      end
   end

   // Response owner register: remembers who owns the SRAM read data that
   // arrives in the following cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_respOwner <= RESP_NONE;
      end else begin
         r_respOwner <= w_respOwnerNext;
      end
   end

   // Next owner is decided fresh every cycle so back-to-back reads pipeline
   // without a bubble. Writes never own a response. The valids are also
   // masked by rst so a response pending when reset arrives is dropped in
   // the reset cycle itself rather than leaking out for one cycle.
   always_comb begin
      w_respOwnerNext = RESP_NONE;
      i_rvalid        = 1'b0;
      d_rvalid        = 1'b0;
      i_rdata         = 32'h0000_0000;
      d_rdata         = 32'h0000_0000;

      if (w_iGnt) begin
         w_respOwnerNext = RESP_INST;
      end else if (w_dGnt && (d_wen == 4'b0000)) begin
         w_respOwnerNext = RESP_DATA;
      end

      case (r_respOwner)
         RESP_INST: begin
            i_rvalid = !rst;
         end
         RESP_DATA: begin
            d_rvalid = !rst;
         end
         default: begin
         end
      endcase

      if (i_rvalid) begin
         i_rdata = sram_rdata;
      end
      if (d_rvalid) begin
         d_rdata = sram_rdata;
      end
   end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_sram_port_arbiter
//
// Drives the arbiter with directed scenarios followed by randomized traffic.
// A behavioural SRAM (one-cycle read latency) sits on the SRAM port, and a
// reference model predicts every output each cycle from the arbitration
// rules, using an integer starvation count and a word array for memory.
// ---------------------------------------------------------------------------
module tb_sram_port_arbiter;

   localparam int STARVE_MAX = 4;

   logic        clk;
   logic        rst;
   logic        i_req;
   logic [31:0] i_addr;
   logic        i_gnt;
   logic        i_rvalid;
   logic [31:0] i_rdata;
   logic        d_req;
   logic [3:0]  d_wen;
   logic [31:0] d_addr;
   logic [31:0] d_wdata;
   logic        d_gnt;
   logic        d_rvalid;
   logic [31:0] d_rdata;
   logic        sram_en;
   logic [3:0]  sram_wen;
   logic [31:0] sram_addr;
   logic [31:0] sram_wdata;
   logic [31:0] sram_rdata;

   int testsRun    = 0;
   int testsFailed = 0;

   // Reference model state
   int          mCnt      = 0;
   int          mPend     = 0;
   logic [31:0] mPendData = 32'h0;
   logic        lastEI    = 1'b0;
   logic        lastED    = 1'b0;
   logic [31:0] refMem [64] = '{0: 32'h3c1d0001, default: 32'h0};

   // Observed values of the most recent cycle, for directed checks
   logic        sIgnt, sDgnt, sIrv, sDrv, sEn;
   logic [3:0]  sWen;
   logic [31:0] sIrd, sDrd;

   // Behavioural SRAM, indexed by word address bits [7:2]
   logic [31:0] sramMem [64] = '{0: 32'h3c1d0001, default: 32'h0};

   sram_port_arbiter #(.STARVE_MAX(STARVE_MAX)) dut (
      .clk        (clk),
      .rst        (rst),
      .i_req      (i_req),
      .i_addr     (i_addr),
      .i_gnt      (i_gnt),
      .i_rvalid   (i_rvalid),
      .i_rdata    (i_rdata),
      .d_req      (d_req),
      .d_wen      (d_wen),
      .d_addr     (d_addr),
      .d_wdata    (d_wdata),
      .d_gnt      (d_gnt),
      .d_rvalid   (d_rvalid),
      .d_rdata    (d_rdata),
      .sram_en    (sram_en),
      .sram_wen   (sram_wen),
      .sram_addr  (sram_addr),
      .sram_wdata (sram_wdata),
      .sram_rdata (sram_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] mergeBytes(input logic [31:0] old,
                                              input logic [31:0] wd,
                                              input logic [3:0]  be);
      logic [31:0] res;
      res = old;
      for (int b = 0; b < 4; b++) begin
         if (be[b]) res[8*b +: 8] = wd[8*b +: 8];
      end
      return res;
   endfunction

   // SRAM: read data appears the cycle after a read enable; otherwise the
   // read bus carries noise so ungated data paths show up.
   always @(posedge clk) begin
      if (sram_en && sram_wen == 4'b0000) begin
         sram_rdata <= sramMem[sram_addr[7:2]];
      end else begin
         sram_rdata <= $urandom;
      end
      if (sram_en && sram_wen != 4'b0000) begin
         sramMem[sram_addr[7:2]] <= mergeBytes(sramMem[sram_addr[7:2]], sram_wdata, sram_wen);
      end
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      testsRun++;
      if (observed !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, observed, expected, $time);
      end
   endtask

   // One clock cycle: compare all outputs against the model mid-cycle, then
   // advance the model at the rising edge. Returns just after that edge.
   task automatic runCycle();
      logic        eIg, eDg, eIrv, eDrv;
      logic [31:0] eAddr, eWd;
      logic [3:0]  eWen;
      @(negedge clk);
      if (rst) begin
         eIg = 1'b0;
         eDg = 1'b0;
      end else if (i_req && d_req) begin
         eIg = (mCnt >= STARVE_MAX);
         eDg = !eIg;
      end else begin
         eIg = i_req;
         eDg = d_req;
      end
      eAddr = eIg ? i_addr : (eDg ? d_addr : 32'h0);
      eWen  = eDg ? d_wen : 4'h0;
      eWd   = eDg ? d_wdata : 32'h0;
      eIrv  = !rst && (mPend == 1);
      eDrv  = !rst && (mPend == 2);

      checkOutput("i_gnt",      32'(i_gnt),      32'(eIg));
      checkOutput("d_gnt",      32'(d_gnt),      32'(eDg));
      checkOutput("sram_en",    32'(sram_en),    32'(eIg | eDg));
      checkOutput("sram_wen",   32'(sram_wen),   32'(eWen));
      checkOutput("sram_addr",  sram_addr,       eAddr);
      checkOutput("sram_wdata", sram_wdata,      eWd);
      checkOutput("i_rvalid",   32'(i_rvalid),   32'(eIrv));
      checkOutput("i_rdata",    i_rdata,         eIrv ? mPendData : 32'h0);
      checkOutput("d_rvalid",   32'(d_rvalid),   32'(eDrv));
      checkOutput("d_rdata",    d_rdata,         eDrv ? mPendData : 32'h0);

      sIgnt = i_gnt;   sDgnt = d_gnt;   sEn = sram_en;  sWen = sram_wen;
      sIrv  = i_rvalid; sIrd = i_rdata; sDrv = d_rvalid; sDrd = d_rdata;

      @(posedge clk);
      if (rst) begin
         mCnt  = 0;
         mPend = 0;
      end else begin
         if (eIg || !i_req) mCnt = 0;
         else if (eDg && mCnt < STARVE_MAX) mCnt = mCnt + 1;
         if (eIg) begin
            mPend     = 1;
            mPendData = refMem[i_addr[7:2]];
         end else if (eDg && d_wen == 4'h0) begin
            mPend     = 2;
            mPendData = refMem[d_addr[7:2]];
         end else begin
            mPend = 0;
         end
         if (eDg && d_wen != 4'h0) begin
            refMem[d_addr[7:2]] = mergeBytes(refMem[d_addr[7:2]], d_wdata, d_wen);
         end
      end
      lastEI = eIg;
      lastED = eDg;
      #1;
   endtask

   // Random traffic obeying the handshake: a request is held stable until
   // granted, may be dropped before its grant, and is renewed afterwards.
   task automatic applyStimulus();
      if (!i_req || lastEI) begin
         i_req  = ($urandom_range(0, 9) < 6);
         i_addr = 32'($urandom_range(0, 15)) << 2;
      end else if ($urandom_range(0, 19) == 0) begin
         i_req = 1'b0;
      end
      if (!d_req || lastED) begin
         d_req   = ($urandom_range(0, 9) < 6);
         d_addr  = 32'($urandom_range(0, 15)) << 2;
         d_wen   = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
         d_wdata = $urandom;
      end else if ($urandom_range(0, 19) == 0) begin
         d_req = 1'b0;
      end
      rst = ($urandom_range(0, 99) == 0);
   endtask

   initial begin
      rst = 1'b1; i_req = 1'b0; i_addr = 32'h0;
      d_req = 1'b0; d_wen = 4'h0; d_addr = 32'h0; d_wdata = 32'h0;
      #1;

      // Reset for two cycles, then idle
      runCycle();
      runCycle();
      rst = 1'b0;
      runCycle();
      checkOutput("t1_en",  32'(sEn),  32'h0);
      checkOutput("t1_irv", 32'(sIrv), 32'h0);
      checkOutput("t1_drv", 32'(sDrv), 32'h0);

      // Single instruction fetch
      i_req = 1'b1; i_addr = 32'hbfc00000;
      runCycle();
      checkOutput("t2_gnt", 32'(sIgnt), 32'h1);
      i_req = 1'b0;
      runCycle();
      checkOutput("t2_rv",  32'(sIrv), 32'h1);
      checkOutput("t2_rd",  sIrd,      32'h3c1d0001);

      // Both requesting: four D wins, then one forced I win, repeating
      i_req = 1'b1; i_addr = 32'h4;
      d_req = 1'b1; d_wen = 4'h0; d_addr = 32'h8;
      for (int k = 0; k < 10; k++) begin
         runCycle();
         checkOutput("t3_ignt", 32'(sIgnt), 32'((k % 5) == 4));
      end
      i_req = 1'b0; d_req = 1'b0;
      runCycle();

      // Write, read back, and a write issued while the read response is due
      d_req = 1'b1; d_wen = 4'hf; d_addr = 32'h10; d_wdata = 32'hdeadbeef;
      runCycle();
      checkOutput("t4_wgnt", 32'(sDgnt), 32'h1);
      checkOutput("t4_wen",  32'(sWen),  32'hf);
      d_wen = 4'h0;
      runCycle();
      checkOutput("t4_norv", 32'(sDrv),  32'h0);
      d_wen = 4'h3; d_addr = 32'h14; d_wdata = 32'h12345678;
      runCycle();
      checkOutput("t4_rv",   32'(sDrv),  32'h1);
      checkOutput("t4_rd",   sDrd,       32'hdeadbeef);
      checkOutput("t4_wen2", 32'(sWen),  32'h3);
      d_req = 1'b0;
      runCycle();
      checkOutput("t4_wnorv", 32'(sDrv), 32'h0);

      // Back-to-back instruction reads
      for (int k = 0; k < 4; k++) begin
         i_req  = (k < 3);
         i_addr = 32'(k) << 2;
         runCycle();
         checkOutput("t5_gnt", 32'(sIgnt), 32'(k < 3));
         checkOutput("t5_rv",  32'(sIrv),  32'(k > 0));
      end

      // Reset right after a D read grant drops the response and the count
      d_req = 1'b1; d_wen = 4'h0; d_addr = 32'h8;
      runCycle();
      checkOutput("t6_gnt", 32'(sDgnt), 32'h1);
      rst = 1'b1; i_req = 1'b1; i_addr = 32'hc;
      for (int k = 0; k < 2; k++) begin
         runCycle();
         checkOutput("t6_drv",  32'(sDrv),  32'h0);
         checkOutput("t6_dgnt", 32'(sDgnt), 32'h0);
         checkOutput("t6_ignt", 32'(sIgnt), 32'h0);
      end
      rst = 1'b0;
      for (int k = 0; k < 5; k++) begin
         runCycle();
         checkOutput("t6_post", 32'(sIgnt), 32'(k == 4));
         if (k == 0) checkOutput("t6_nodrv", 32'(sDrv), 32'h0);
      end
      i_req = 1'b0; d_req = 1'b0;
      runCycle();

      // Randomized traffic
      for (int n = 0; n < 500; n++) begin
         applyStimulus();
         runCycle();
      end

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
